// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - MIPS ID stage: regfile with bypass, branch resolve, ID/EX register (optional macro DECODE_BNE_EN)
module decode_stage_pipe #(
    parameter int DATA_W  = 32,
    parameter int NREGS   = 32,
    parameter int SHAMT_W = 5,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic [31:0]       instr_id32,
    input  logic [DATA_W-1:0] pc_plus4_id32,
    input  logic              branch_i,
    input  logic              bne_i,
    input  logic [1:0]        fwd_rd1_sel_i,
    input  logic [1:0]        fwd_rd2_sel_i,
    input  logic [DATA_W-1:0] alu_out_im,
    input  logic              enable_wreg_iwb,
    input  logic [AW-1:0]     dst_reg_addr_iwb,
    input  logic [DATA_W-1:0] res_iwb,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              pc_src_o,
    output logic [DATA_W-1:0] pc_branch_o,
    output logic              valid_o,
    output logic [5:0]        op_o,
    output logic [5:0]        funct_o,
    output logic [AW-1:0]     rs_o,
    output logic [AW-1:0]     rt_o,
    output logic [AW-1:0]     rd_o,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o,
    output logic [DATA_W-1:0] sign_imm_o,
    output logic [DATA_W-1:0] shamt_o
);

    typedef struct packed {
        logic              valid;
        logic [5:0]        op;
        logic [5:0]        funct;
        logic [AW-1:0]     rs;
        logic [AW-1:0]     rt;
        logic [AW-1:0]     rd;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] sign_imm;
        logic [DATA_W-1:0] shamt;
    } idex_t;

    logic [DATA_W-1:0] rf_q [NREGS];
    logic [DATA_W-1:0] rf_d [NREGS];
    idex_t             idex_q, idex_d;

    logic [AW-1:0]     rs_addr, rt_addr, rd_addr;
    logic [DATA_W-1:0] rd1_bp, rd2_bp;
    logic [DATA_W-1:0] fwd1, fwd2;
    logic [DATA_W-1:0] sign_imm, shamt_ext;
    logic              eq;

    assign rs_addr   = instr_id32[21+AW-1:21];
    assign rt_addr   = instr_id32[16+AW-1:16];
    assign rd_addr   = instr_id32[11+AW-1:11];
    assign sign_imm  = {{(DATA_W-16){instr_id32[15]}}, instr_id32[15:0]};
    assign shamt_ext = {{(DATA_W-SHAMT_W){1'b0}}, instr_id32[6+SHAMT_W-1:6]};

    // Regfile next state: single WB write port, r0 is never written
    always_comb begin
        rf_d = rf_q;
        if (enable_wreg_iwb && dst_reg_addr_iwb != '0) begin
            rf_d[dst_reg_addr_iwb] = res_iwb;
        end
    end

    // Regfile storage, cleared by async reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    // Read ports with write-through bypass so WB data is visible in the same cycle
    always_comb begin
        rd1_bp = rf_q[rs_addr];
        rd2_bp = rf_q[rt_addr];
        if (rs_addr == '0) begin
            rd1_bp = '0;
        end else if (enable_wreg_iwb && dst_reg_addr_iwb == rs_addr) begin
            rd1_bp = res_iwb;
        end
        if (rt_addr == '0) begin
            rd2_bp = '0;
        end else if (enable_wreg_iwb && dst_reg_addr_iwb == rt_addr) begin
            rd2_bp = res_iwb;
        end
    end

    // Branch operand forwarding from MEM ALU result or WB result
    always_comb begin
        case (fwd_rd1_sel_i)
            2'd1:    fwd1 = alu_out_im;
            2'd2:    fwd1 = res_iwb;
            default: fwd1 = rd1_bp;
        endcase
        case (fwd_rd2_sel_i)
            2'd1:    fwd2 = alu_out_im;
            2'd2:    fwd2 = res_iwb;
            default: fwd2 = rd2_bp;
        endcase
    end

    assign eq          = (fwd1 == fwd2);
    assign pc_branch_o = pc_plus4_id32 + (sign_imm << 2);

`ifdef DECODE_BNE_EN
    assign pc_src_o = valid_i & branch_i & (eq ^ bne_i);
`else
    logic unused_bne;
    assign unused_bne = bne_i;
    assign pc_src_o   = valid_i & branch_i & eq;
`endif

    // ID/EX next state: flush beats stall, stall holds, otherwise capture
    always_comb begin
        idex_d = idex_q;
        if (flush_i) begin
            idex_d = '0;
        end else if (!stall_i) begin
            idex_d.valid    = valid_i;
            idex_d.op       = instr_id32[31:26];
            idex_d.funct    = instr_id32[5:0];
            idex_d.rs       = rs_addr;
            idex_d.rt       = rt_addr;
            idex_d.rd       = rd_addr;
            idex_d.rd1      = rd1_bp;
            idex_d.rd2      = rd2_bp;
            idex_d.sign_imm = sign_imm;
            idex_d.shamt    = shamt_ext;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign valid_o    = idex_q.valid;
    assign op_o       = idex_q.op;
    assign funct_o    = idex_q.funct;
    assign rs_o       = idex_q.rs;
    assign rt_o       = idex_q.rt;
    assign rd_o       = idex_q.rd;
    assign rd1_o      = idex_q.rd1;
    assign rd2_o      = idex_q.rd2;
    assign sign_imm_o = idex_q.sign_imm;
    assign shamt_o    = idex_q.shamt;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb/tb_decode_stage_pipe.sv - scoreboard bench for decode_stage_pipe
module tb_decode_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, branch_i, bne_i, wen, stall, flush;
    logic [31:0] instr, pc4, alu, res;
    logic [1:0]  fsel1, fsel2;
    logic [4:0]  dst;
    logic        pc_src_o, valid_o;
    logic [31:0] pc_branch_o, rd1_o, rd2_o, sign_imm_o, shamt_o;
    logic [5:0]  op_o, funct_o;
    logic [4:0]  rs_o, rt_o, rd_o;

    always #5 clk = ~clk;

    decode_stage_pipe dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .instr_id32(instr),
        .pc_plus4_id32(pc4), .branch_i(branch_i), .bne_i(bne_i),
        .fwd_rd1_sel_i(fsel1), .fwd_rd2_sel_i(fsel2), .alu_out_im(alu),
        .enable_wreg_iwb(wen), .dst_reg_addr_iwb(dst), .res_iwb(res),
        .stall_i(stall), .flush_i(flush), .pc_src_o(pc_src_o),
        .pc_branch_o(pc_branch_o), .valid_o(valid_o), .op_o(op_o),
        .funct_o(funct_o), .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o),
        .rd1_o(rd1_o), .rd2_o(rd2_o), .sign_imm_o(sign_imm_o), .shamt_o(shamt_o)
    );

    typedef struct packed {
        logic        valid;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] simm;
        logic [31:0] shamt;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        last_e;
    logic [31:0] mrf [32];
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wen && dst == a) return res;
        return mrf[a];
    endfunction

    function automatic logic [31:0] m_fwd(input logic [1:0] sel, input logic [4:0] a);
        case (sel)
            2'd1:    return alu;
            2'd2:    return res;
            default: return m_read(a);
        endcase
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        last_e = '0;
        sb_q.delete();
    endtask

    task automatic idle();
        valid_i = 0; branch_i = 0; bne_i = 0; wen = 0; stall = 0; flush = 0;
        instr = 0; pc4 = 0; alu = 0; res = 0; fsel1 = 0; fsel2 = 0; dst = 0;
    endtask

    // Called just after a negedge with inputs set; returns at the next negedge
    task automatic step(input string tag);
        exp_t        e;
        logic [31:0] simm, f1, f2;
        logic        exp_src;
        #1;
        simm = {{16{instr[15]}}, instr[15:0]};
        f1   = m_fwd(fsel1, instr[25:21]);
        f2   = m_fwd(fsel2, instr[20:16]);
`ifdef DECODE_BNE_EN
        exp_src = valid_i & branch_i & ((f1 == f2) ^ bne_i);
`else
        exp_src = valid_i & branch_i & (f1 == f2);
`endif
        check({tag, ".pc_src"}, {63'd0, pc_src_o}, {63'd0, exp_src});
        check({tag, ".pc_br"}, {32'd0, pc_branch_o}, {32'd0, pc4 + (simm << 2)});
        if (flush) e = '0;
        else if (stall) e = last_e;
        else begin
            e.valid = valid_i;
            e.op    = instr[31:26];
            e.funct = instr[5:0];
            e.rs    = instr[25:21];
            e.rt    = instr[20:16];
            e.rd    = instr[15:11];
            e.rd1   = m_read(instr[25:21]);
            e.rd2   = m_read(instr[20:16]);
            e.simm  = simm;
            e.shamt = {27'd0, instr[10:6]};
        end
        sb_q.push_back(e);
        @(posedge clk);
        if (wen && dst != 5'd0) mrf[dst] = res;
        last_e = e;
        #1;
        e = sb_q.pop_front();
        check({tag, ".valid"}, {63'd0, valid_o}, {63'd0, e.valid});
        check({tag, ".op"}, {58'd0, op_o}, {58'd0, e.op});
        check({tag, ".funct"}, {58'd0, funct_o}, {58'd0, e.funct});
        check({tag, ".rs"}, {59'd0, rs_o}, {59'd0, e.rs});
        check({tag, ".rt"}, {59'd0, rt_o}, {59'd0, e.rt});
        check({tag, ".rd"}, {59'd0, rd_o}, {59'd0, e.rd});
        check({tag, ".rd1"}, {32'd0, rd1_o}, {32'd0, e.rd1});
        check({tag, ".rd2"}, {32'd0, rd2_o}, {32'd0, e.rd2});
        check({tag, ".simm"}, {32'd0, sign_imm_o}, {32'd0, e.simm});
        check({tag, ".shamt"}, {32'd0, shamt_o}, {32'd0, e.shamt});
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        idle();
        wen = 1; dst = a; res = d;
        step("wr");
    endtask

    initial begin
        idle();
        model_reset();
        rst_n = 0;
        #12;
        check("rst.valid", {63'd0, valid_o}, 64'd0);
        check("rst.rd1", {32'd0, rd1_o}, 64'd0);
        check("rst.simm", {32'd0, sign_imm_o}, 64'd0);
        @(negedge clk);
        rst_n = 1;

        // WB write r5 with same-cycle read through bypass
        idle();
        valid_i = 1; instr = mk_r(5'd5, 5'd0, 5'd3, 5'd7, 6'h20);
        wen = 1; dst = 5'd5; res = 32'h0000_00AA;
        step("bypass");
        check("bypass.rd1_aa", {32'd0, rd1_o}, 64'hAA);
        check("bypass.valid1", {63'd0, valid_o}, 64'd1);

        // r0 write is discarded
        idle();
        valid_i = 1; instr = mk_r(5'd0, 5'd5, 5'd1, 5'd0, 6'h21);
        wen = 1; dst = 5'd0; res = 32'hFFFF_FFFF;
        step("r0");
        check("r0.rd1_zero", {32'd0, rd1_o}, 64'd0);
        idle();
        valid_i = 1; instr = mk_r(5'd0, 5'd5, 5'd1, 5'd0, 6'h21);
        step("r0_after");
        check("r0.after_zero", {32'd0, rd1_o}, 64'd0);
        check("r5.stored", {32'd0, rd2_o}, 64'hAA);

        wr(5'd1, 32'd3);
        wr(5'd2, 32'd7);

        // beq r1,r2 with forwarding
        idle();
        valid_i = 1; branch_i = 1; instr = mk_i(6'h04, 5'd1, 5'd2, 16'h0010);
        fsel2 = 2'd1; alu = 32'd3;
        #1 check("beq.fwd_alu", {63'd0, pc_src_o}, 64'd1);
        step("beq_alu");
        idle();
        valid_i = 1; branch_i = 1; instr = mk_i(6'h04, 5'd1, 5'd2, 16'h0010);
        #1 check("beq.sel0", {63'd0, pc_src_o}, 64'd0);
        step("beq_rf");
        idle();
        valid_i = 1; branch_i = 1; instr = mk_i(6'h04, 5'd1, 5'd2, 16'h0010);
        fsel1 = 2'd2; res = 32'd7;
        #1 check("beq.fwd_wb", {63'd0, pc_src_o}, 64'd1);
        step("beq_wb");
        idle();
        branch_i = 1; instr = mk_i(6'h04, 5'd1, 5'd1, 16'h0010);
        #1 check("beq.invalid", {63'd0, pc_src_o}, 64'd0);
        step("beq_inv");
        check("beq.inv_valid0", {63'd0, valid_o}, 64'd0);

        // Branch target arithmetic including wrap
        idle();
        pc4 = 32'h100; instr = mk_i(6'h04, 5'd0, 5'd0, 16'hFFFC);
        #1 check("tgt.neg", {32'd0, pc_branch_o}, 64'hF0);
        step("tgt_neg");
        check("tgt.simm", {32'd0, sign_imm_o}, 64'hFFFF_FFFC);
        idle();
        pc4 = 32'h100; instr = mk_i(6'h04, 5'd0, 5'd0, 16'h0004);
        #1 check("tgt.pos", {32'd0, pc_branch_o}, 64'h110);
        step("tgt_pos");
        idle();
        pc4 = 32'hFFFF_FFFC; instr = mk_i(6'h04, 5'd0, 5'd0, 16'h0004);
        #1 check("tgt.wrap", {32'd0, pc_branch_o}, 64'hC);
        step("tgt_wrap");

        // Stall holds, then flush+stall clears
        idle();
        valid_i = 1; instr = mk_r(5'd1, 5'd2, 5'd9, 5'd4, 6'h00);
        step("ld");
        for (int i = 0; i < 2; i++) begin
            idle();
            stall = 1; valid_i = 1; instr = $urandom;
            step("stall");
            check("stall.rd2", {32'd0, rd2_o}, 64'd7);
            check("stall.shamt", {32'd0, shamt_o}, 64'd4);
        end
        idle();
        stall = 1; flush = 1; valid_i = 1; instr = mk_r(5'd1, 5'd2, 5'd9, 5'd4, 6'h2A);
        step("flush");
        check("flush.valid", {63'd0, valid_o}, 64'd0);
        check("flush.rd1", {32'd0, rd1_o}, 64'd0);

        // bne behaviour depends on build
        wr(5'd3, 32'd9);
        wr(5'd4, 32'd9);
        wr(5'd6, 32'd8);
        idle();
        valid_i = 1; branch_i = 1; bne_i = 1; instr = mk_i(6'h05, 5'd3, 5'd4, 16'h0001);
`ifdef DECODE_BNE_EN
        #1 check("bne.eq", {63'd0, pc_src_o}, 64'd0);
`else
        #1 check("bne.eq", {63'd0, pc_src_o}, 64'd1);
`endif
        step("bne_eq");
        idle();
        valid_i = 1; branch_i = 1; bne_i = 1; instr = mk_i(6'h05, 5'd3, 5'd6, 16'h0001);
`ifdef DECODE_BNE_EN
        #1 check("bne.ne", {63'd0, pc_src_o}, 64'd1);
`else
        #1 check("bne.ne", {63'd0, pc_src_o}, 64'd0);
`endif
        step("bne_ne");

        // A few random decodes against the model
        for (int i = 0; i < 8; i++) begin
            idle();
            valid_i = 1'($urandom); branch_i = 1'($urandom); instr = $urandom;
            pc4 = $urandom; fsel1 = 2'($urandom); fsel2 = 2'($urandom);
            alu = $urandom_range(0, 9); wen = 1'($urandom); dst = 5'($urandom);
            res = $urandom_range(0, 9);
            step("rand");
        end

        // Asynchronous reset mid-operation
        idle();
        valid_i = 1; instr = mk_r(5'd5, 5'd3, 5'd1, 5'd0, 6'h20);
        step("pre_rst");
        check("pre_rst.valid", {63'd0, valid_o}, 64'd1);
        #2 rst_n = 0;
        #1;
        check("arst.valid", {63'd0, valid_o}, 64'd0);
        check("arst.rd1", {32'd0, rd1_o}, 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        idle();
        valid_i = 1; instr = mk_r(5'd5, 5'd3, 5'd1, 5'd0, 6'h20);
        step("post_rst");
        check("post_rst.r5", {32'd0, rd1_o}, 64'd0);
        check("post_rst.valid", {63'd0, valid_o}, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
